// File: rtl/sipo_frame_rx.sv
// sipo_frame_rx: serial-in/parallel-out receive framer with a valid/ready holding register.
// Optional frame parity flag (perr_o, OddParity) is built when SIPO_PARITY_CHECK_EN is defined.
//
// state | meaning (implicit in bitcnt)
// IDLE  | bitcnt == 0, waiting for the first bit of a frame
// SHIFT | bitcnt  > 0, frame in progress
module sipo_frame_rx #(
   parameter int Width    = 10,
   parameter bit MsbFirst = 1'b0
`ifdef SIPO_PARITY_CHECK_EN
   ,
   parameter bit OddParity = 1'b0
`endif
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         din_i,
   input  logic                         en_i,
   input  logic                         clr_i,
   input  logic                         ready_i,
   output logic [Width-1:0]             dout_o,
   output logic                         valid_o,
   output logic                         ovr_o,
   output logic                         busy_o,
   output logic [$clog2(Width+1)-1:0]   bitcnt_o
`ifdef SIPO_PARITY_CHECK_EN
   ,
   output logic                         perr_o
`endif
);

   localparam int CntW = $clog2(Width+1);

   logic [Width-1:0] sr;
   logic [Width-1:0] sr_right;
   logic [Width-1:0] sr_left;
   logic [Width-1:0] sr_next;
   logic [CntW-1:0]  bitcnt;
   logic [Width-1:0] dout;
   logic             valid;
   logic             ovr;
   logic             last;
   logic             complete;
   logic             load;

   assign sr_right = {din_i, sr[Width-1:1]};
   assign sr_left  = {sr[Width-2:0], din_i};
   assign sr_next  = MsbFirst ? sr_left : sr_right;

   // clr_i discards a bit arriving in the same cycle, so it also cancels completion
   assign last     = en_i && (bitcnt == CntW'(Width - 1));
   assign complete = last && !clr_i;
   assign load     = complete && (!valid || ready_i);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         sr     <= '0;
         bitcnt <= '0;
         dout   <= '0;
         valid  <= 1'b0;
         ovr    <= 1'b0;
      end else begin
         if (clr_i) begin
            sr     <= '0;
            bitcnt <= '0;
         end else if (en_i) begin
            sr     <= sr_next;
            bitcnt <= last ? '0 : bitcnt + 1'b1;
         end

         if (clr_i)
            ovr <= 1'b0;
         else if (complete && valid && !ready_i)
            ovr <= 1'b1;

         if (load) begin
            dout  <= sr_next;
            valid <= 1'b1;
         end else if (valid && ready_i) begin
            valid <= 1'b0;
         end
      end
   end

`ifdef SIPO_PARITY_CHECK_EN
   logic perr;

   // Follows the holding register: loaded with it, dropped when it is consumed
   always_ff @(posedge clk_i) begin
      if (rst_i)
         perr <= 1'b0;
      else if (load)
         perr <= (^sr_next) ^ OddParity;
      else if (valid && ready_i)
         perr <= 1'b0;
   end

   assign perr_o = perr;
`endif

   assign dout_o   = dout;
   assign valid_o  = valid;
   assign ovr_o    = ovr;
   assign busy_o   = (bitcnt != '0);
   assign bitcnt_o = bitcnt;

endmodule

// File: tb/tb_sipo_frame_rx.sv
// Bench for sipo_frame_rx: two Width=8 instances (LSB-first and MSB-first) share stimulus
// and are compared against a queue-based frame model.
module tb_sipo_frame_rx;

   logic clk = 1'b0;
   logic rst = 1'b0, din = 1'b0, en = 1'b0, clr = 1'b0, rdy = 1'b0;

   logic [7:0] dl, dm;
   logic       vl, vm, ol, om, bl, bm;
   logic [3:0] cl, cm;
`ifdef SIPO_PARITY_CHECK_EN
   logic       pl, pm;
`endif

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   sipo_frame_rx #(.Width(8), .MsbFirst(1'b0)
`ifdef SIPO_PARITY_CHECK_EN
      , .OddParity(1'b0)
`endif
   ) u_lsb (
      .clk_i(clk), .rst_i(rst), .din_i(din), .en_i(en), .clr_i(clr), .ready_i(rdy),
      .dout_o(dl), .valid_o(vl), .ovr_o(ol), .busy_o(bl), .bitcnt_o(cl)
`ifdef SIPO_PARITY_CHECK_EN
      , .perr_o(pl)
`endif
   );

   sipo_frame_rx #(.Width(8), .MsbFirst(1'b1)
`ifdef SIPO_PARITY_CHECK_EN
      , .OddParity(1'b0)
`endif
   ) u_msb (
      .clk_i(clk), .rst_i(rst), .din_i(din), .en_i(en), .clr_i(clr), .ready_i(rdy),
      .dout_o(dm), .valid_o(vm), .ovr_o(om), .busy_o(bm), .bitcnt_o(cm)
`ifdef SIPO_PARITY_CHECK_EN
      , .perr_o(pm)
`endif
   );

   // Reference model: bits of the current frame in arrival order, plus holding register.
   logic       bits[$];
   logic       mv = 1'b0, movr = 1'b0, mperr = 1'b0;
   logic [7:0] mdl = '0, mdm = '0;

   task automatic model_edge();
      logic       done;
      logic       hs;
      logic [7:0] fl, fm;
      if (rst) begin
         bits.delete();
         mv = 1'b0; movr = 1'b0; mperr = 1'b0; mdl = '0; mdm = '0;
         return;
      end
      hs   = mv && rdy;
      done = 1'b0;
      if (clr) begin
         bits.delete();
         movr = 1'b0;
      end else if (en) begin
         bits.push_back(din);
         if (bits.size() == 8) done = 1'b1;
      end
      if (done) begin
         fl = '0; fm = '0;
         for (int i = 0; i < 8; i++) begin
            fl[i]     = bits[i];
            fm[7 - i] = bits[i];
         end
         bits.delete();
         if (!mv || rdy) begin
            mv = 1'b1; mdl = fl; mdm = fm;
            mperr = ($countones(fl) % 2) == 1;
         end else begin
            movr = 1'b1;
         end
      end else if (hs) begin
         mv = 1'b0; mperr = 1'b0;
      end
   endtask

   function automatic logic [29:0] observed();
      return {dl, dm, vl, vm, ol, om, bl, bm, cl, cm};
   endfunction

   function automatic logic [29:0] expected();
      logic       busy;
      logic [3:0] c;
      busy = (bits.size() != 0);
      c    = 4'(bits.size());
      return {mdl, mdm, mv, mv, movr, movr, busy, busy, c, c};
   endfunction

   task automatic step(input logic r, input logic e, input logic d, input logic c, input logic rd);
      @(negedge clk);
      rst = r; en = e; din = d; clr = c; rdy = rd;
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic send_frame(input logic [7:0] v, input logic rd_last);
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, v[i], 1'b0, (i == 7) ? rd_last : 1'b0);
   endtask

   task automatic test_reset();
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if (observed() !== 30'd0) begin
         n_fail++;
         $display("FAIL reset: got %h want %h", observed(), 30'd0);
      end
   endtask

   task automatic test_directed_frame();
      logic [7:0] seq;
      seq = 8'b0100_1101;   // bits 1,0,1,1,0,0,1,0 in arrival order (bit 0 first)
      for (int i = 0; i < 8; i++) begin
         step(1'b0, 1'b1, seq[i], 1'b0, 1'b0);
         n_checks++;
         if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL frame bit %0d: got %h want %h", i, observed(), expected());
         end
      end
      n_checks++;
      if (dl !== 8'h4D || dm !== 8'hB2 || vl !== 1'b1 || vm !== 1'b1 || cl !== 4'd0 || bl !== 1'b0) begin
         n_fail++;
         $display("FAIL frame result: got dl=%h dm=%h v=%b cnt=%0d want dl=4d dm=b2 v=1 cnt=0",
                  dl, dm, vl, cl);
      end
   endtask

   task automatic test_overrun();
      send_frame(8'hFF, 1'b0);
      n_checks++;
      if (ol !== 1'b1 || om !== 1'b1 || dl !== 8'h4D || vl !== 1'b1 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL overrun: got ovr=%b dl=%h v=%b want ovr=1 dl=4d v=1", ol, dl, vl);
      end
      step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      n_checks++;
      if (ol !== 1'b0 || vl !== 1'b1 || dl !== 8'h4D || observed() !== expected()) begin
         n_fail++;
         $display("FAIL overrun clear: got ovr=%b v=%b dl=%h want ovr=0 v=1 dl=4d", ol, vl, dl);
      end
   endtask

   task automatic test_handshake_same_cycle();
      send_frame(8'h5A, 1'b1);
      n_checks++;
      if (dl !== 8'h5A || dm !== 8'h5A || vl !== 1'b1 || ol !== 1'b0 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL handshake: got dl=%h dm=%h v=%b ovr=%b want 5a 5a 1 0", dl, dm, vl, ol);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (vl !== 1'b0 || dl !== 8'h5A || observed() !== expected()) begin
         n_fail++;
         $display("FAIL consume: got v=%b dl=%h want v=0 dl=5a", vl, dl);
      end
   endtask

   task automatic test_clr_mid_frame();
      logic [7:0] v;
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
      n_checks++;
      if (cl !== 4'd3 || bl !== 1'b1 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL clr pre: got cnt=%0d busy=%b want cnt=3 busy=1", cl, bl);
      end
      step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      n_checks++;
      if (cl !== 4'd0 || bl !== 1'b0 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL clr: got cnt=%0d busy=%b want cnt=0 busy=0", cl, bl);
      end
      v = 8'($urandom);
      send_frame(v, 1'b0);
      n_checks++;
      if (dl !== v || vl !== 1'b1 || observed() !== expected()) begin
         n_fail++;
         $display("FAIL clr frame: got dl=%h v=%b want dl=%h v=1", dl, vl, v);
      end
   endtask

   task automatic test_reset_mid_frame();
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 1'($urandom), 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      n_checks++;
      if (observed() !== 30'd0) begin
         n_fail++;
         $display("FAIL reset mid-frame: got %h want %h", observed(), 30'd0);
      end
`ifdef SIPO_PARITY_CHECK_EN
      n_checks++;
      if (pl !== 1'b0 || pm !== 1'b0) begin
         n_fail++;
         $display("FAIL reset perr: got %b%b want 00", pl, pm);
      end
`endif
   endtask

`ifdef SIPO_PARITY_CHECK_EN
   task automatic test_parity();
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      send_frame(8'h07, 1'b0);
      n_checks++;
      if (pl !== 1'b1 || pm !== 1'b1) begin
         n_fail++;
         $display("FAIL parity 07: got %b%b want 11", pl, pm);
      end
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if (pl !== 1'b0) begin
         n_fail++;
         $display("FAIL parity consume: got %b want 0", pl);
      end
      send_frame(8'h03, 1'b0);
      n_checks++;
      if (pl !== 1'b0 || pm !== 1'b0 || vl !== 1'b1) begin
         n_fail++;
         $display("FAIL parity 03: got %b%b v=%b want 00 v=1", pl, pm, vl);
      end
   endtask
`endif

   task automatic test_random();
      logic r, e, d, c, rd;
      for (int cyc = 0; cyc < 600; cyc++) begin
         r  = ($urandom_range(0, 99) == 0);
         e  = ($urandom_range(0, 3) != 0);
         d  = 1'($urandom);
         c  = ($urandom_range(0, 39) == 0);
         rd = ($urandom_range(0, 2) == 0);
         step(r, e, d, c, rd);
         n_checks++;
         if (observed() !== expected()) begin
            n_fail++;
            $display("FAIL random cyc %0d: got %h want %h", cyc, observed(), expected());
         end
`ifdef SIPO_PARITY_CHECK_EN
         n_checks++;
         if (pl !== mperr || pm !== mperr) begin
            n_fail++;
            $display("FAIL random perr cyc %0d: got %b%b want %b", cyc, pl, pm, mperr);
         end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_directed_frame();
      test_overrun();
      test_handshake_same_cycle();
      test_clr_mid_frame();
      test_reset_mid_frame();
`ifdef SIPO_PARITY_CHECK_EN
      test_parity();
`endif
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
